// File: rtl/parity_checked_fifo_pkg.sv
// Shared types and the parity helper for the parity-checked FIFO.
package parity_fifo_pkg;

    typedef enum logic {PAR_ODD = 1'b0, PAR_EVEN = 1'b1} parity_e;
    typedef enum logic {PB_MSB = 1'b0, PB_LSB = 1'b1} pbit_pos_e;

    // Words are zero-extended to this width; zero padding leaves the XOR unchanged.
    localparam int PARITY_MAX_W = 1024;

    // Even sense expects XOR 0 and odd expects XOR 1, so the word is bad when XOR equals the sense bit.
    function automatic logic parity_bad(input logic [PARITY_MAX_W-1:0] word, input parity_e parity);
        return (^word) == logic'(parity);
    endfunction

endpackage

// File: rtl/parity_checked_fifo_if.sv
// Handshake bus of the parity-checked FIFO; slave is the FIFO, master is the surrounding logic.
interface parity_checked_fifo_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 17,
    parameter int ERR_CNT_W  = 8
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    logic                  valid_in;
    logic                  grant_out;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_out;
    logic                  grant_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  err_out;
    logic [LEVEL_W-1:0]    level;
    logic [ERR_CNT_W-1:0]  err_count;

    modport slave (
        input  valid_in, data_in, grant_in,
        output grant_out, valid_out, data_out, err_out, level, err_count
    );

    modport master (
        output valid_in, data_in, grant_in,
        input  grant_out, valid_out, data_out, err_out, level, err_count
    );
endinterface

// File: rtl/parity_checked_fifo_head_check.sv
// Combinational parity check of the FIFO head word and parity-bit masking for data_out.
module parity_head_check
    import parity_fifo_pkg::*;
#(
    parameter int   DATA_WIDTH = 17,
    parameter logic PARITY     = 1'b1,
    parameter logic P_BIT      = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] head,
    output logic                  bad,
    output logic [DATA_WIDTH-1:0] data_masked
);
    localparam logic [DATA_WIDTH-1:0] LSB_MASK = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] PMASK    =
        (pbit_pos_e'(P_BIT) == PB_LSB) ? LSB_MASK : MSB_MASK;

    assign bad         = parity_bad(PARITY_MAX_W'(head), parity_e'(PARITY));
    assign data_masked = head & ~PMASK;
endmodule

// File: rtl/parity_checked_fifo.sv
// Parity-checked FIFO: flags or drops bad words at the head and counts them.
// Define PARITY_FIFO_ERR_CNT_EN to build the saturating error counter; otherwise err_count is 0.
module parity_checked_fifo
    import parity_fifo_pkg::*;
#(
    parameter int   FIFO_DEPTH = 4,
    parameter int   DATA_WIDTH = 17,
    parameter logic PARITY     = 1'b1,
    parameter logic P_BIT      = 1'b1,
    parameter logic DROP_BAD   = 1'b0,
    parameter int   ERR_CNT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    parity_checked_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      level_q;

    logic                  full, empty;
    logic                  push, pop, drop;
    logic                  head_bad, bad;
    logic [DATA_WIDTH-1:0] head_word, head_masked;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);

    // Gating the read path while empty gives data_out = 0 out of reset despite unreset memory.
    assign head_word = empty ? '0 : mem[rd_ptr];

    parity_head_check #(
        .DATA_WIDTH (DATA_WIDTH),
        .PARITY     (PARITY),
        .P_BIT      (P_BIT)
    ) u_head_check (
        .head        (head_word),
        .bad         (head_bad),
        .data_masked (head_masked)
    );

    assign bad  = !empty && head_bad;
    assign drop = DROP_BAD && bad;
    assign push = bus.valid_in && !full;
    assign pop  = (bus.valid_out && bus.grant_in) || drop;

    assign bus.grant_out = !full;
    assign bus.valid_out = DROP_BAD ? (!empty && !head_bad) : !empty;
    assign bus.err_out   = DROP_BAD ? 1'b0 : bad;
    assign bus.data_out  = head_masked;
    assign bus.level     = level_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef PARITY_FIFO_ERR_CNT_EN
    logic                 err_inc;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Covers both a bad word popped in flag mode and one dropped in drop mode.
    assign err_inc = pop && bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt_q <= '0;
        else if (err_inc && (err_cnt_q != '1))
            err_cnt_q <= err_cnt_q + 1'b1;
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_parity_checked_fifo.sv
// Scoreboard bench: flag-mode FIFO (depth 4, LSB parity) and drop-mode FIFO (depth 3, MSB parity, 2-bit counter).
module tb_parity_checked_fifo;

    typedef struct {
        logic [16:0] data;
        logic        err;
    } exp_t;

`ifdef PARITY_FIFO_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic [16:0] a_in   [4] = '{17'h00003, 17'h00005, 17'h00006, 17'h10001};
    logic [16:0] a_exp  [4] = '{17'h00002, 17'h00004, 17'h00006, 17'h10000};
    logic [16:0] b_in   [3] = '{17'h10001, 17'h00003, 17'h18000};
    logic [16:0] b_exp  [3] = '{17'h00001, 17'h00003, 17'h08000};
    logic [16:0] bd_in  [4] = '{17'h10001, 17'h00001, 17'h10000, 17'h00003};
    logic [16:0] bd_exp [4] = '{17'h00001, 17'h00000, 17'h00000, 17'h00003};
    logic        bd_good[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          bd_cnt [4] = '{0, 0, 1, 2};
    logic [16:0] bs_in  [5] = '{17'h00001, 17'h10000, 17'h00002, 17'h00004, 17'h00008};

    parity_checked_fifo_if #(.FIFO_DEPTH(4), .DATA_WIDTH(17), .ERR_CNT_W(8)) ifa ();
    parity_checked_fifo_if #(.FIFO_DEPTH(3), .DATA_WIDTH(17), .ERR_CNT_W(2)) ifb ();

    parity_checked_fifo #(
        .FIFO_DEPTH(4), .DATA_WIDTH(17), .PARITY(1'b1), .P_BIT(1'b1),
        .DROP_BAD(1'b0), .ERR_CNT_W(8)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    parity_checked_fifo #(
        .FIFO_DEPTH(3), .DATA_WIDTH(17), .PARITY(1'b1), .P_BIT(1'b0),
        .DROP_BAD(1'b1), .ERR_CNT_W(2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int n, input int w);
        int m;
        m = (1 << w) - 1;
        return CNT_EN ? ((n > m) ? m : n) : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [16:0] d, input logic [16:0] eo, input logic ee);
        ifa.data_in  = d;
        ifa.valid_in = 1'b1;
        qa.push_back('{data: eo, err: ee});
        step();
        ifa.valid_in = 1'b0;
    endtask

    // Monitors: one pop per cycle where the consumer takes the presented word.
    always @(negedge clk) begin
        if (!rst && ifa.valid_out && ifa.grant_in) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_word actual=%0h required=none", ifa.data_out);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_data_out", 32'(ifa.data_out), 32'(e.data));
                chk("a_err_out", 32'(ifa.err_out), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ifb.valid_out && ifb.grant_in) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_word actual=%0h required=none", ifb.data_out);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_data_out", 32'(ifb.data_out), 32'(e.data));
                chk("b_err_out", 32'(ifb.err_out), 32'(e.err));
            end
        end
    end

    initial begin
        rst          = 1'b1;
        ifa.valid_in = 1'b0;
        ifa.grant_in = 1'b0;
        ifa.data_in  = '0;
        ifb.valid_in = 1'b0;
        ifb.grant_in = 1'b0;
        ifb.data_in  = '0;
        repeat (2) step();
        rst = 1'b0;
        step();

        chk("a_rst_grant", 32'(ifa.grant_out), 32'd1);
        chk("a_rst_valid", 32'(ifa.valid_out), 32'd0);
        chk("a_rst_err", 32'(ifa.err_out), 32'd0);
        chk("a_rst_data", 32'(ifa.data_out), 32'd0);
        chk("a_rst_level", 32'(ifa.level), 32'd0);
        chk("a_rst_cnt", 32'(ifa.err_count), 32'd0);
        chk("b_rst_grant", 32'(ifb.grant_out), 32'd1);
        chk("b_rst_valid", 32'(ifb.valid_out), 32'd0);
        chk("b_rst_data", 32'(ifb.data_out), 32'd0);
        chk("b_rst_level", 32'(ifb.level), 32'd0);

        // Flag mode: fill to full, then a push against a full FIFO alongside a pop
        for (int i = 0; i < 4; i++) begin
            push_a(a_in[i], a_exp[i], 1'b0);
            chk("a_fill_level", 32'(ifa.level), 32'(i + 1));
        end
        chk("a_full_grant", 32'(ifa.grant_out), 32'd0);
        ifa.data_in  = 17'h0000F;
        ifa.valid_in = 1'b1;
        ifa.grant_in = 1'b1;
        step();
        ifa.valid_in = 1'b0;
        chk("a_full_pushpop_level", 32'(ifa.level), 32'd3);
        chk("a_regrant", 32'(ifa.grant_out), 32'd1);
        repeat (3) step();
        ifa.grant_in = 1'b0;
        chk("a_drain_level", 32'(ifa.level), 32'd0);
        chk("a_drain_valid", 32'(ifa.valid_out), 32'd0);

        push_a(17'h00001, 17'h00000, 1'b1);
        chk("a_bad_valid", 32'(ifa.valid_out), 32'd1);
        chk("a_bad_err", 32'(ifa.err_out), 32'd1);
        chk("a_bad_cnt_prepop", 32'(ifa.err_count), 32'd0);
        ifa.grant_in = 1'b1;
        step();
        ifa.grant_in = 1'b0;
        chk("a_bad_cnt", 32'(ifa.err_count), 32'(exp_cnt(1, 8)));
        chk("a_empty_err", 32'(ifa.err_out), 32'd0);

        push_a(17'h00003, 17'h00002, 1'b0);
        ifa.grant_in = 1'b1;
        push_a(17'h00005, 17'h00004, 1'b0);
        chk("a_pushpop_level", 32'(ifa.level), 32'd1);
        step();
        ifa.grant_in = 1'b0;
        chk("a_pushpop_drain", 32'(ifa.level), 32'd0);

        // Asynchronous reset mid-cycle with three words in flight
        for (int i = 0; i < 3; i++) push_a(a_in[i], a_exp[i], 1'b0);
        chk("a_pre_rst_level", 32'(ifa.level), 32'd3);
        chk("a_pre_rst_cnt", 32'(ifa.err_count), 32'(exp_cnt(1, 8)));
        #2 rst = 1'b1;
        #1;
        chk("a_async_rst_level", 32'(ifa.level), 32'd0);
        chk("a_async_rst_valid", 32'(ifa.valid_out), 32'd0);
        chk("a_async_rst_cnt", 32'(ifa.err_count), 32'd0);
        chk("a_async_rst_grant", 32'(ifa.grant_out), 32'd1);
        qa.delete();
        rst = 1'b0;
        push_a(17'h10001, 17'h10000, 1'b0);
        chk("a_post_rst_push", 32'(ifa.level), 32'd1);
        ifa.grant_in = 1'b1;
        step();
        ifa.grant_in = 1'b0;
        chk("a_post_rst_drain", 32'(ifa.level), 32'd0);

        // Drop mode, depth 3: fill, over-push, drain with pointer wrap
        for (int i = 0; i < 3; i++) begin
            ifb.data_in  = b_in[i];
            ifb.valid_in = 1'b1;
            qb.push_back('{data: b_exp[i], err: 1'b0});
            step();
            chk("b_fill_level", 32'(ifb.level), 32'(i + 1));
        end
        chk("b_full_grant", 32'(ifb.grant_out), 32'd0);
        ifb.data_in = 17'h00003;
        step();
        ifb.valid_in = 1'b0;
        chk("b_full_ignore_level", 32'(ifb.level), 32'd3);
        ifb.grant_in = 1'b1;
        repeat (3) step();
        ifb.grant_in = 1'b0;
        chk("b_drain_level", 32'(ifb.level), 32'd0);

        // good, bad, bad, good streamed with the consumer always ready
        ifb.grant_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifb.data_in  = bd_in[i];
            ifb.valid_in = 1'b1;
            if (bd_good[i]) qb.push_back('{data: bd_exp[i], err: 1'b0});
            step();
            chk("b_drop_cnt_step", 32'(ifb.err_count), 32'(exp_cnt(bd_cnt[i], 2)));
            chk("b_drop_level_step", 32'(ifb.level), 32'd1);
        end
        ifb.valid_in = 1'b0;
        step();
        ifb.grant_in = 1'b0;
        chk("b_drop_cnt", 32'(ifb.err_count), 32'(exp_cnt(2, 2)));
        chk("b_drop_level", 32'(ifb.level), 32'd0);

        // Saturation: five bad words with no consumer grant
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("b_sat_rst_cnt", 32'(ifb.err_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            ifb.data_in  = bs_in[i];
            ifb.valid_in = 1'b1;
            step();
            chk("b_sat_valid", 32'(ifb.valid_out), 32'd0);
            chk("b_sat_err_out", 32'(ifb.err_out), 32'd0);
            chk("b_sat_level", 32'(ifb.level), 32'd1);
        end
        ifb.valid_in = 1'b0;
        step();
        chk("b_sat_cnt", 32'(ifb.err_count), 32'(exp_cnt(5, 2)));
        chk("b_sat_empty", 32'(ifb.level), 32'd0);

        step();
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
